nibbler_ctrl: RTL
=================

Name: nibbler_ctrl

Overview:
- Instruction fetch/decode/sequencing controller for the 4-bit datapath.
- Fetches 8-bit instruction bytes from program ROM and decodes them into the ALU's 3-bit command code plus datapath strobes.
- Latches the ALU's Carry/Zero outputs into a flag register and uses them to resolve conditional jumps.
- Sits upstream of the ALU and drives its command input. It also consumes the ALU flag outputs.

Parameters:
- ADDR_W, 12, program and data address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- program_byte  in  8  ROM data at pc_out; valid combinationally in the same cycle.
- c_in  in  1  ALU Carry output.
- z_in  in  1  ALU Zero output.
- pc_out  out  ADDR_W  program ROM address (the PC register).
- alu_command  out  3  ALU command code: 000 pass A, 001 compare (A-B), 010 pass B, 011 add, 100 NAND.
- imm_out  out  4  operand nibble of the current instruction (ALU B source when bsel=0).
- bsel  out  1  ALU B source: 0 immediate, 1 data memory/input port.
- mem_addr  out  ADDR_W  data memory address {operand, second byte}.
- load_accu  out  1  accumulator load strobe.
- mem_we  out  1  data RAM write strobe; accumulator is driven through the ALU pass-A path.
- mem_oe  out  1  data RAM output enable.
- in_oe  out  1  input port enable.
- out_we  out  1  output port write strobe.
- c_flag  out  1  registered Carry flag.
- z_flag  out  1  registered Zero flag.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.

Behaviour:
- Reset is asynchronous, active-high. It forces:
  - PC=RESET_PC, state=FETCH;
  - instruction register (IR) and address register (AR) = 0;
  - c_flag=z_flag=0;
  - all strobes and instr_done = 0;
  - alu_command=000, bsel=0.
- Reset asserted mid-instruction aborts that instruction. No strobe fires in the reset cycle.

States:
- FETCH:
  - IR <= program_byte; PC <= PC+1.
  - Next state is FETCH2 if opcode IR[7:4] is two-byte, else EXEC.
- FETCH2:
  - AR[7:0] <= program_byte; PC <= PC+1; next EXEC.
  - mem_addr = {IR[3:0], AR[7:0]}.
- EXEC:
  - Exactly one cycle; strobes are asserted only here. Next state FETCH.
  - instr_done=1.

Timing:
- One-byte instructions take 2 cycles; two-byte instructions take 3 cycles.
- alu_command, bsel, imm_out and mem_addr come from IR/AR and are stable throughout EXEC.

Opcodes (2B = two-byte):
- 0 JC (2B): taken if c_flag=1.
- 1 JNC (2B): taken if c_flag=0.
- 2 CMPI: command 001, bsel=0; flags loaded, accumulator not loaded.
- 3 CMPM (2B): command 001, bsel=1, mem_oe; flags loaded.
- 4 LIT: command 010, bsel=0, load_accu.
- 5 IN: command 010, bsel=1, in_oe, load_accu.
- 6 LD (2B): command 010, bsel=1, mem_oe, load_accu.
- 7 ST (2B): command 000, mem_we.
- 8 JZ (2B): taken if z_flag=1.
- 9 JNZ (2B): taken if z_flag=0.
- A ADDI: command 011, bsel=0, load_accu; flags loaded.
- B ADDM (2B): command 011, bsel=1, mem_oe, load_accu; flags loaded.
- C JMP (2B): always taken.
- D OUT: command 000, out_we.
- E NANDI: command 100, bsel=0, load_accu; flags loaded.
- F NANDM (2B): command 100, bsel=1, mem_oe, load_accu; flags loaded.

Flags:
- c_flag <= c_in and z_flag <= z_in at the end of EXEC, only for opcodes 2, 3, A, B, E, F.
- All other opcodes hold the flags.

Jumps:
- Taken jump: PC <= {IR[3:0], AR[7:0]} at the end of EXEC.
- Not taken: PC already points at the next instruction.
- Jump conditions use flags registered before this instruction.
- Jump opcodes assert no strobe; alu_command=000.

Boundary conditions:
- PC wraps 0xFFF->0x000, including when the second byte is fetched across the wrap.
- A jump to its own address loops indefinitely with a 3-cycle period.

Test Plan:
- Reset release with ROM[0]=0x45 (LIT 5):
  - FETCH at pc_out=0, EXEC next cycle;
  - alu_command=010, bsel=0, imm_out=5, load_accu=1, instr_done=1;
  - pc_out=1, flags stay 0.
- ROM[0..1]=0xC1,0x23 (JMP 0x123):
  - pc_out sequence 0,1,2 then 0x123 in the following FETCH;
  - no strobes asserted.
- ADDI 0x A9 with c_in=1, z_in=0 in EXEC:
  - c_flag=1, z_flag=0 after EXEC;
  - then ROM 0x00,0x40 (JC 0x040) is taken, so the next pc_out is 0x040;
  - repeat with c_in=0: falls through to PC+2.
- ROM 0x72,0x34 (ST 0x234):
  - FETCH2 then EXEC with mem_addr=0x234, alu_command=000, mem_we=1 for exactly one cycle;
  - flags unchanged.
- PC=0xFFF holding 0x6A, ROM[0x000]=0x55 (LD 0xA55):
  - mem_addr=0xA55, mem_oe=1, load_accu=1;
  - next pc_out=0x001.
- Assert reset during FETCH2 of a JMP:
  - all outputs return to reset values immediately (asynchronous);
  - after release, FETCH restarts at pc_out=0 with no EXEC strobe from the aborted instruction.

Source files
------------

// File: rtl/nibbler_ctrl.sv
// nibbler_ctrl: fetch/decode/sequencing controller for the 4-bit nibbler datapath.
// Fetches one or two instruction bytes from program ROM, drives the ALU command and
// datapath strobes for a single execute cycle, and keeps the Carry/Zero flag register
// used to resolve conditional jumps.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FETCH  | latch opcode byte into IR, advance PC
// S_FETCH2 | latch second (address) byte into AR, advance PC
// S_EXEC   | assert strobes, update flags, optionally load jump target

module nibbler_ctrl #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        program_byte,
    input  logic              c_in,
    input  logic              z_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic [2:0]        alu_command,
    output logic [3:0]        imm_out,
    output logic              bsel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              load_accu,
    output logic              mem_we,
    output logic              mem_oe,
    output logic              in_oe,
    output logic              out_we,
    output logic              c_flag,
    output logic              z_flag,
    output logic              instr_done
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_FETCH2 = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

    localparam logic [2:0] CMD_PASS_A = 3'b000;
    localparam logic [2:0] CMD_CMP    = 3'b001;
    localparam logic [2:0] CMD_PASS_B = 3'b010;
    localparam logic [2:0] CMD_ADD    = 3'b011;
    localparam logic [2:0] CMD_NAND   = 3'b100;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        ar_q, ar_d;
    logic              c_q, c_d;
    logic              z_q, z_d;

    logic [3:0]        opcode;
    logic [11:0]       target;
    logic              exec;

    logic [2:0]        dec_cmd;
    logic              dec_bsel;
    logic              dec_la;
    logic              dec_we;
    logic              dec_oe;
    logic              dec_in;
    logic              dec_out;
    logic              dec_flags;
    logic              dec_taken;

    // Opcodes that carry a second (low address) byte.
    function automatic logic is_two_byte(input logic [3:0] op);
        logic r;
        case (op)
            4'h0, 4'h1, 4'h3, 4'h6, 4'h7,
            4'h8, 4'h9, 4'hB, 4'hC, 4'hF: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

    assign opcode = ir_q[7:4];
    assign target = {ir_q[3:0], ar_q};
    assign exec   = (state_q == S_EXEC);

    // Instruction decode from IR; jump conditions use the flags held before this instruction.
    always_comb begin
        dec_cmd   = CMD_PASS_A;
        dec_bsel  = 1'b0;
        dec_la    = 1'b0;
        dec_we    = 1'b0;
        dec_oe    = 1'b0;
        dec_in    = 1'b0;
        dec_out   = 1'b0;
        dec_flags = 1'b0;
        dec_taken = 1'b0;
        case (opcode)
            4'h0: dec_taken = c_q;
            4'h1: dec_taken = ~c_q;
            4'h2: begin
                dec_cmd   = CMD_CMP;
                dec_flags = 1'b1;
            end
            4'h3: begin
                dec_cmd   = CMD_CMP;
                dec_bsel  = 1'b1;
                dec_oe    = 1'b1;
                dec_flags = 1'b1;
            end
            4'h4: begin
                dec_cmd = CMD_PASS_B;
                dec_la  = 1'b1;
            end
            4'h5: begin
                dec_cmd  = CMD_PASS_B;
                dec_bsel = 1'b1;
                dec_in   = 1'b1;
                dec_la   = 1'b1;
            end
            4'h6: begin
                dec_cmd  = CMD_PASS_B;
                dec_bsel = 1'b1;
                dec_oe   = 1'b1;
                dec_la   = 1'b1;
            end
            4'h7: dec_we = 1'b1;
            4'h8: dec_taken = z_q;
            4'h9: dec_taken = ~z_q;
            4'hA: begin
                dec_cmd   = CMD_ADD;
                dec_la    = 1'b1;
                dec_flags = 1'b1;
            end
            4'hB: begin
                dec_cmd   = CMD_ADD;
                dec_bsel  = 1'b1;
                dec_oe    = 1'b1;
                dec_la    = 1'b1;
                dec_flags = 1'b1;
            end
            4'hC: dec_taken = 1'b1;
            4'hD: dec_out = 1'b1;
            4'hE: begin
                dec_cmd   = CMD_NAND;
                dec_la    = 1'b1;
                dec_flags = 1'b1;
            end
            4'hF: begin
                dec_cmd   = CMD_NAND;
                dec_bsel  = 1'b1;
                dec_oe    = 1'b1;
                dec_la    = 1'b1;
                dec_flags = 1'b1;
            end
            default: dec_cmd = CMD_PASS_A;
        endcase
    end

    // Sequencer next-state: fetch one or two bytes, then a single execute cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ar_d    = ar_q;
        c_d     = c_q;
        z_d     = z_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = program_byte;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = is_two_byte(program_byte[7:4]) ? S_FETCH2 : S_EXEC;
            end
            S_FETCH2: begin
                ar_d    = program_byte;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (dec_flags) begin
                    c_d = c_in;
                    z_d = z_in;
                end
                if (dec_taken) begin
                    pc_d = ADDR_W'(target);
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State, PC, instruction/address and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            ar_q    <= 8'h00;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ar_q    <= ar_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    assign pc_out      = pc_q;
    assign alu_command = dec_cmd;
    assign bsel        = dec_bsel;
    assign imm_out     = ir_q[3:0];
    assign mem_addr    = ADDR_W'(target);
    assign load_accu   = exec & dec_la;
    assign mem_we      = exec & dec_we;
    assign mem_oe      = exec & dec_oe;
    assign in_oe       = exec & dec_in;
    assign out_we      = exec & dec_out;
    assign c_flag      = c_q;
    assign z_flag      = z_q;
    assign instr_done  = exec;

endmodule
